ad_meas: RTL and testbench

ADC capture-and-measure block on the receive side of the sine DAC/ADC loop. It samples the 8-bit ADC bus `ad_in` over a window of `WIN_LEN` valid samples, triggered by `start`. For each window it reports max, min and peak-to-peak amplitude, the number of rising mid-level crossings (with hysteresis), and their sample span, so downstream logic can compute frequency. It also flags clipping at either rail.

---
 rtl/ad_pkg.sv | 18 +
 rtl/ad_meas_if.sv | 28 ++
 rtl/ad_schmitt.sv | 47 ++++
 rtl/ad_meas.sv | 156 +++++++++++++++
 tb/tb_ad_meas.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/ad_pkg.sv
// Shared types and default thresholds for the ADC capture-and-measure block.
// Enums cover the window FSM and the Schmitt trigger level state.
package ad_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } meas_state_e;

   typedef enum logic {
      LOW  = 1'b0,
      HIGH = 1'b1
   } schmitt_state_e;

   localparam int MID_DEFAULT  = 128;
   localparam int HYST_DEFAULT = 8;

endpackage

// File: rtl/ad_meas_if.sv
// Sample/control/result bundle of ad_meas.
// The master side feeds samples and start; the slave side (the block) returns results.
interface ad_meas_if #(
   parameter int DW    = 8,
   parameter int CNT_W = 11
);
   logic [DW-1:0]    ad_in;
   logic             ad_vld;
   logic             start;
   logic             busy;
   logic             meas_vld;
   logic [DW-1:0]    vmax;
   logic [DW-1:0]    vmin;
   logic [DW-1:0]    vpp;
   logic [CNT_W-1:0] cross_cnt;
   logic [CNT_W-1:0] span;
   logic             ovr;

   modport master (
      output ad_in, ad_vld, start,
      input  busy, meas_vld, vmax, vmin, vpp, cross_cnt, span, ovr
   );

   modport slave (
      input  ad_in, ad_vld, start,
      output busy, meas_vld, vmax, vmin, vpp, cross_cnt, span, ovr
   );
endinterface

// File: rtl/ad_schmitt.sv
// Mid-level Schmitt trigger: the first sample after prime_clr sets the level without
// counting; afterwards a LOW->HIGH transition raises rise for the consuming cycle.
module ad_schmitt
   import ad_pkg::*;
#(
   parameter int DW   = 8,
   parameter int MID  = MID_DEFAULT,
   parameter int HYST = HYST_DEFAULT
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [DW-1:0]  sample,
   input  logic           valid,
   input  logic           prime_clr,
   output schmitt_state_e state,
   output logic           rise
);

   localparam logic [DW-1:0] MID_LVL  = DW'(MID);
   localparam logic [DW-1:0] RISE_LVL = DW'(MID + HYST);
   localparam logic [DW-1:0] FALL_LVL = DW'(MID - HYST);

   logic primed;

   assign rise = valid && primed && (state == LOW) && (sample >= RISE_LVL);

   // Samples strictly between the two levels leave the state untouched
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= LOW;
         primed <= 1'b0;
      end else if (prime_clr) begin
         state  <= LOW;
         primed <= 1'b0;
      end else if (valid) begin
         if (!primed) begin
            primed <= 1'b1;
            state  <= (sample >= MID_LVL) ? HIGH : LOW;
         end else if (rise) begin
            state <= HIGH;
         end else if ((state == HIGH) && (sample <= FALL_LVL)) begin
            state <= LOW;
         end
      end
   end

endmodule

// File: rtl/ad_meas.sv
// ADC window measurement: max/min/peak-to-peak, rising mid-level crossings and their
// sample span, plus rail clipping, reported once per WIN_LEN consumed samples.
module ad_meas
   import ad_pkg::*;
#(
   parameter int DW      = 8,
   parameter int WIN_LEN = 1024,
   parameter int MID     = MID_DEFAULT,
   parameter int HYST    = HYST_DEFAULT,
   parameter int CNT_W   = $clog2(WIN_LEN + 1)
) (
   input  logic     clk,
   input  logic     rst,
   ad_meas_if.slave bus
);

   localparam logic [0:0]       ST_IDLE  = 1'(IDLE);
   localparam logic [0:0]       ST_RUN   = 1'(RUN);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIN_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [DW-1:0]    RAIL_HI  = {DW{1'b1}};

   logic [DW-1:0]    ad_q;
   logic             vld_q;
   logic [0:0]       state;
   logic [CNT_W-1:0] idx;
   logic [DW-1:0]    cur_max;
   logic [DW-1:0]    cur_min;
   logic             ovr_acc;
   logic [CNT_W-1:0] cross_acc;
   logic [CNT_W-1:0] first_idx;
   logic [CNT_W-1:0] last_idx;

   logic             meas_vld_r;
   logic [DW-1:0]    vmax_r;
   logic [DW-1:0]    vmin_r;
   logic [DW-1:0]    vpp_r;
   logic [CNT_W-1:0] cross_r;
   logic [CNT_W-1:0] span_r;
   logic             ovr_r;

   logic             accept;
   logic             consume;
   logic             first_smp;
   logic             win_end;
   logic             rise;
   schmitt_state_e   sch_state_unused;

   logic [DW-1:0]    nxt_max;
   logic [DW-1:0]    nxt_min;
   logic             nxt_ovr;
   logic [CNT_W-1:0] nxt_cross;
   logic [CNT_W-1:0] nxt_first;
   logic [CNT_W-1:0] nxt_last;
   logic [CNT_W-1:0] nxt_span;

   assign accept    = (state == ST_IDLE) && bus.start;
   assign consume   = (state == ST_RUN) && vld_q;
   assign first_smp = (idx == '0);
   assign win_end   = consume && (idx == LAST_IDX);

   ad_schmitt #(
      .DW   (DW),
      .MID  (MID),
      .HYST (HYST)
   ) u_schmitt (
      .clk       (clk),
      .rst       (rst),
      .sample    (ad_q),
      .valid     (consume),
      .prime_clr (accept),
      .state     (sch_state_unused),
      .rise      (rise)
   );

   // Next-value views include the sample being consumed, so the window-end edge
   // can load results that already contain the final sample
   assign nxt_max   = (first_smp || (ad_q > cur_max)) ? ad_q : cur_max;
   assign nxt_min   = (first_smp || (ad_q < cur_min)) ? ad_q : cur_min;
   assign nxt_ovr   = ovr_acc || (ad_q == '0) || (ad_q == RAIL_HI);
   assign nxt_cross = (rise && (cross_acc != CNT_MAX)) ? cross_acc + 1'b1 : cross_acc;
   assign nxt_first = (rise && (cross_acc == '0)) ? idx : first_idx;
   assign nxt_last  = rise ? idx : last_idx;
   assign nxt_span  = (nxt_cross >= CNT_W'(2)) ? (nxt_last - nxt_first) : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         ad_q  <= '0;
         vld_q <= 1'b0;
      end else begin
         ad_q  <= bus.ad_in;
         vld_q <= bus.ad_vld;
      end
   end

   // Window FSM, accumulators and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         idx        <= '0;
         cur_max    <= '0;
         cur_min    <= '0;
         ovr_acc    <= 1'b0;
         cross_acc  <= '0;
         first_idx  <= '0;
         last_idx   <= '0;
         meas_vld_r <= 1'b0;
         vmax_r     <= '0;
         vmin_r     <= '0;
         vpp_r      <= '0;
         cross_r    <= '0;
         span_r     <= '0;
         ovr_r      <= 1'b0;
      end else begin
         meas_vld_r <= 1'b0;
         if (accept) begin
            state     <= ST_RUN;
            idx       <= '0;
            cur_max   <= '0;
            cur_min   <= '0;
            ovr_acc   <= 1'b0;
            cross_acc <= '0;
            first_idx <= '0;
            last_idx  <= '0;
         end else if (consume) begin
            idx       <= idx + 1'b1;
            cur_max   <= nxt_max;
            cur_min   <= nxt_min;
            ovr_acc   <= nxt_ovr;
            cross_acc <= nxt_cross;
            first_idx <= nxt_first;
            last_idx  <= nxt_last;
            if (win_end) begin
               state      <= ST_IDLE;
               meas_vld_r <= 1'b1;
               vmax_r     <= nxt_max;
               vmin_r     <= nxt_min;
               vpp_r      <= nxt_max - nxt_min;
               cross_r    <= nxt_cross;
               span_r     <= nxt_span;
               ovr_r      <= nxt_ovr;
            end
         end
      end
   end

   assign bus.busy      = (state == ST_RUN);
   assign bus.meas_vld  = meas_vld_r;
   assign bus.vmax      = vmax_r;
   assign bus.vmin      = vmin_r;
   assign bus.vpp       = vpp_r;
   assign bus.cross_cnt = cross_r;
   assign bus.span      = span_r;
   assign bus.ovr       = ovr_r;

endmodule

// File: tb/tb_ad_meas.sv
// Scoreboard bench for ad_meas: windows of 16 samples are scored against a plain
// arithmetic reference; a monitor pops expectations on every meas_vld pulse.
module tb_ad_meas;

   localparam int DW   = 8;
   localparam int WIN  = 16;
   localparam int CW   = 5;
   localparam int MID  = 128;
   localparam int HYST = 8;

   typedef struct {
      int vmax;
      int vmin;
      int vpp;
      int cnt;
      int span;
      int ovr;
      int due;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   ad_meas_if #(.DW(DW), .CNT_W(CW)) bus ();

   ad_meas #(
      .DW      (DW),
      .WIN_LEN (WIN),
      .MID     (MID),
      .HYST    (HYST),
      .CNT_W   (CW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input int required);
      tests++;
      if (actual !== required) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, required);
      end
   endtask

   // Reference: walk the window sample list with a two-level trigger
   function automatic exp_t model(input int s[WIN]);
      exp_t e;
      bit   high;
      int   first;
      int   last;
      e.vmax = s[0];
      e.vmin = s[0];
      e.cnt  = 0;
      e.ovr  = 0;
      e.due  = 0;
      high   = (s[0] >= MID);
      first  = -1;
      last   = -1;
      for (int i = 0; i < WIN; i++) begin
         if (s[i] > e.vmax) e.vmax = s[i];
         if (s[i] < e.vmin) e.vmin = s[i];
         if (s[i] == 0 || s[i] == 255) e.ovr = 1;
         if (i > 0) begin
            if (!high && s[i] >= MID + HYST) begin
               high = 1'b1;
               e.cnt++;
               if (first < 0) first = i;
               last = i;
            end else if (high && s[i] <= MID - HYST) begin
               high = 1'b0;
            end
         end
      end
      e.vpp  = e.vmax - e.vmin;
      e.span = (e.cnt >= 2) ? (last - first) : 0;
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (rst !== 1'b1 && bus.meas_vld === 1'b1) begin
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_meas_vld", 32'd1, 0);
         end else begin
            e = exp_q.pop_front();
            checkOutput("latency", cyc, e.due);
            checkOutput("vmax", bus.vmax, e.vmax);
            checkOutput("vmin", bus.vmin, e.vmin);
            checkOutput("vpp", bus.vpp, e.vpp);
            checkOutput("cross_cnt", bus.cross_cnt, e.cnt);
            checkOutput("span", bus.span, e.span);
            checkOutput("ovr", bus.ovr, e.ovr);
         end
      end
   end

   function automatic void buildWindow(input int kind, output int s[WIN]);
      int near[10];
      near = '{0, 'h70, 'h78, 'h79, 'h7F, 'h80, 'h87, 'h88, 'h90, 255};
      for (int i = 0; i < WIN; i++) begin
         case (kind)
            0:       s[i] = 'h80;
            1, 6:    s[i] = ((i % 4) < 2) ? 'h40 : 'hC0;
            2:       s[i] = (i % 2) ? 'h86 : 'h80;
            3:       s[i] = (i % 2) ? 'h88 : 'h87;
            4:       s[i] = near[$urandom_range(0, 9)];
            default: s[i] = $urandom_range(0, 255);
         endcase
      end
      if (kind == 3) s[7] = 'h78;
      if (kind == 6) s[5] = 'hFF;
   endfunction

   // Drives one full window; start goes out together with sample 0
   task automatic applyStimulus(input int kind, input bit gaps, input bit restart_mid,
                                input bit back_to_back);
      int   s[WIN];
      exp_t e;
      int   k;
      buildWindow(kind, s);
      e = model(s);
      for (int i = 0; i < WIN; i++) begin
         @(posedge clk); #1;
         checkOutput((i == 0) ? "busy_idle" : "busy_run", bus.busy, (i == 0) ? 0 : 1);
         bus.ad_in  = DW'(s[i]);
         bus.ad_vld = 1'b1;
         bus.start  = (i == 0) || (restart_mid && i == 8);
         if (i == WIN - 1) begin
            e.due = cyc + 2;
            exp_q.push_back(e);
         end else if (gaps) begin
            @(posedge clk); #1;
            bus.ad_vld = 1'b0;
            bus.ad_in  = DW'($urandom_range(0, 255));
            bus.start  = 1'b0;
         end
      end
      @(posedge clk); #1;
      bus.ad_vld = 1'b0;
      bus.start  = 1'b0;
      if (!back_to_back) begin
         k = 0;
         while (bus.busy === 1'b1 && k < 50) begin
            @(posedge clk); #1;
            k++;
         end
         if (k == 50) checkOutput("busy_timeout", 32'd1, 0);
         // Rail samples in IDLE must be dropped, including the one left in vld_q at start
         for (int j = 0; j < 3; j++) begin
            @(posedge clk); #1;
            bus.ad_vld = 1'b1;
            bus.ad_in  = (j % 2) ? 8'h00 : 8'hFF;
         end
         checkOutput("hold_vmax", bus.vmax, e.vmax);
         checkOutput("hold_ovr", bus.ovr, e.ovr);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_busy"}, bus.busy, 0);
      checkOutput({tag, "_meas_vld"}, bus.meas_vld, 0);
      checkOutput({tag, "_vmax"}, bus.vmax, 0);
      checkOutput({tag, "_vmin"}, bus.vmin, 0);
      checkOutput({tag, "_vpp"}, bus.vpp, 0);
      checkOutput({tag, "_cross_cnt"}, bus.cross_cnt, 0);
      checkOutput({tag, "_span"}, bus.span, 0);
      checkOutput({tag, "_ovr"}, bus.ovr, 0);
   endtask

   initial begin
      int k;
      rst        = 1'b1;
      bus.ad_in  = '0;
      bus.ad_vld = 1'b0;
      bus.start  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkAllZero("reset");
      rst = 1'b0;

      applyStimulus(0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1, 1'b0, 1'b0, 1'b0);
      applyStimulus(2, 1'b0, 1'b0, 1'b0);
      applyStimulus(3, 1'b0, 1'b0, 1'b0);
      applyStimulus(1, 1'b1, 1'b1, 1'b0);
      applyStimulus(1, 1'b0, 1'b0, 1'b1);
      applyStimulus(4, 1'b0, 1'b0, 1'b0);
      for (int w = 0; w < 6; w++)
         applyStimulus(4 + (w % 2), 1'(w % 3 == 0), 1'b0, 1'b0);
      applyStimulus(6, 1'b0, 1'b0, 1'b0);

      // Abort a window partway through; no result may appear for it
      for (int i = 0; i < 9; i++) begin
         @(posedge clk); #1;
         bus.ad_in  = 8'hFF;
         bus.ad_vld = 1'b1;
         bus.start  = (i == 0);
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      rst       = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst        = 1'b0;
      bus.ad_vld = 1'b0;
      checkAllZero("abort");
      repeat (20) @(posedge clk);
      #1;
      checkOutput("abort_idle_busy", bus.busy, 0);
      applyStimulus(5, 1'b0, 1'b0, 1'b0);

      k = 0;
      while (exp_q.size() != 0 && k < 200) begin
         @(posedge clk);
         k++;
      end
      if (exp_q.size() != 0) checkOutput("missing_meas_vld", exp_q.size(), 0);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
